tlul_arbiter2: RTL and testbench
================================

# tlul_arbiter2

Two-to-one TileLink-UL/UH A-channel arbiter with D-channel response routing, placed in front of the on-chip SRAM slave so two masters (e.g. instruction fetch and data/DMA port) share it. Round-robin grant on A, lock held across multi-beat A messages, one master-index bit appended as the downstream source MSB, and D responses steered back by that bit. All data paths are combinational; only grant/lock state is registered.

## Interface
- TL_RS, 4, upstream source width; downstream source is TL_RS+1 bits
- TL_AW, 16, address width
- arb_clock_i  in  1  clock
- arb_reset_i  in  1  reset; synchronous, active-high
- mN_a_opcode/param/size/source/address/mask/data/corrupt  in  3/3/4/TL_RS/TL_AW/4/32/1  master N A fields (N=0,1)
- mN_a_valid  in  1; mN_a_ready  out  1
- mN_d_opcode/param/size/source/denied/data/corrupt  out  3/2/4/TL_RS/1/32/1  master N D fields
- mN_d_valid  out  1; mN_d_ready  in  1
- s_a_opcode/param/size/source/address/mask/data/corrupt  out  3/3/4/TL_RS+1/TL_AW/4/32/1  to slave
- s_a_valid  out  1; s_a_ready  in  1
- s_d_opcode/param/size/source/denied/data/corrupt  in  3/2/4/TL_RS+1/1/32/1  from slave
- s_d_valid  in  1; s_d_ready  out  1

## Operation
- State: IDLE, HOLD, BURST; 1-bit rr pointer (preferred master); 10-bit beats_left; 1-bit gnt.
- IDLE: if only one mN_a_valid, grant it; if both, grant rr pointer. s_a = granted master's fields, s_a_source = {gnt, mN_a_source}; mN_a_ready = s_a_ready for granted master only, 0 for the other.
- Beats of A message: multi-beat iff opcode in {PutFullData 0, PutPartialData 1, ArithmeticData 2, LogicalData 3} and size>2; beats = 2^(size-2), size clamped to 12 (1024 beats). Get (4) and size<=2 are single-beat.
- IDLE, granted valid, not accepted -> HOLD, gnt registered (grant frozen; TL valid stability).
- IDLE/HOLD, first beat accepted: single-beat -> IDLE, rr <= ~gnt; multi-beat -> BURST, beats_left <= beats-1, gnt held.
- BURST: only gnt master routed; each handshake decrements beats_left; handshake at beats_left==1 -> IDLE, rr <= ~gnt.
- Other master's a_ready is 0 in HOLD and BURST regardless of s_a_ready.
- D: s_d_source[TL_RS] selects master; mN_d_valid = s_d_valid & (sel==N); mN_d_source = s_d_source[TL_RS-1:0]; other D fields broadcast; s_d_ready = selected mN_d_ready. No D-side state; multi-beat read responses pass through unchanged.

## Timing
- A and D paths: 0-cycle combinational; grant change takes effect the cycle after the last-beat handshake.
- Reset (sync): state IDLE, rr=0 (m0 preferred), beats_left=0, gnt=0. While arb_reset_i high: s_a_valid=0, m0/m1_a_ready=0, m0/m1_d_valid=0, s_d_ready=0.
- Reset mid-burst aborts lock immediately; no partial-burst completion.
- Simultaneous valids in IDLE: rr winner, loser sees a_ready=0 and keeps valid.
- Granted master dropping valid mid-BURST: lock retained, s_a_valid=0 until it resumes.
- Back-to-back: with both requesting continuously, single-beat grants alternate m0,m1,m0,... at one per cycle when s_a_ready=1.

## Structure
- Shared package tlul_pkg: opcode constants (Get, PutFullData, PutPartialData, ArithmeticData, LogicalData, AccessAck 0, AccessAckData 1), state enum, function for beat count from opcode/size.
- Single module; no sub-module needed.

## Test plan
- m0 Get size 2 src 3 alone, s_a_ready=1 -> s_a_source=0x03 same cycle; slave D src 0x03 -> m0_d_valid=1, m1_d_valid=0.
- Both issue Get each cycle, s_a_ready=1 -> grant order m0,m1,m0,m1; m1 requests carry source MSB 1 (src 5 -> 0x15).
- m1 PutFullData size 4 (4 beats) while m0 requests -> 4 consecutive m1 beats, m0_a_ready=0 throughout, m0 granted cycle after 4th beat.
- m0 valid with s_a_ready=0 for 3 cycles, m1 rises at cycle 1 with rr=1 -> grant stays m0 (HOLD) until accepted.
- 8-beat read response (size 5) to m1 with m1_d_ready toggling -> all 8 beats reach m1 only, s_d_ready mirrors m1_d_ready.
- Assert reset during beat 2 of a 16-beat PutFullData -> outputs zero during reset; after release state IDLE, next single m1 Get granted immediately.

Source files
------------

// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TileLink-UL constants, arbiter state type and A-message beat-count helper
package tlul_pkg;
  localparam logic [2:0] OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] OP_PUT_PART  = 3'd1;
  localparam logic [2:0] OP_ARITH     = 3'd2;
  localparam logic [2:0] OP_LOGIC     = 3'd3;
  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_ACK       = 3'd0;
  localparam logic [2:0] OP_ACK_DATA  = 3'd1;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_BURST} arb_state_e;
  // Beats minus one for an A message; zero means single-beat. Size clamps at 12 (1024 beats).
  function automatic logic [9:0] beats_m1(input logic [2:0] opcode, input logic [3:0] size);
    logic [3:0] w_sz;
    w_sz = (size > 4'd12) ? 4'd12 : size;
    return (opcode <= OP_LOGIC && size > 4'd2) ? 10'((11'd1 << (w_sz - 4'd2)) - 11'd1) : 10'd0;
  endfunction
endpackage

// File: rtl/tlul_arbiter2.sv
// tlul_arbiter2: 2:1 TL-UL A-channel round-robin arbiter with burst lock and D-channel routing
//   arb_clock_i/arb_reset_i : clock, sync active-high reset
//   m0_a_*/m1_a_*           : upstream master A channels (source TL_RS bits)
//   m0_d_*/m1_d_*           : upstream master D channels
//   s_a_*/s_d_*             : downstream slave channels (source TL_RS+1 bits, MSB = master index)
module tlul_arbiter2
  import tlul_pkg::*;
#(
  parameter int TL_RS = 4,
  parameter int TL_AW = 16
) (
  input  logic             arb_clock_i,
  input  logic             arb_reset_i,
  input  logic [2:0]       m0_a_opcode,
  input  logic [2:0]       m0_a_param,
  input  logic [3:0]       m0_a_size,
  input  logic [TL_RS-1:0] m0_a_source,
  input  logic [TL_AW-1:0] m0_a_address,
  input  logic [3:0]       m0_a_mask,
  input  logic [31:0]      m0_a_data,
  input  logic             m0_a_corrupt,
  input  logic             m0_a_valid,
  output logic             m0_a_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [1:0]       m0_d_param,
  output logic [3:0]       m0_d_size,
  output logic [TL_RS-1:0] m0_d_source,
  output logic             m0_d_denied,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_corrupt,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,
  input  logic [2:0]       m1_a_opcode,
  input  logic [2:0]       m1_a_param,
  input  logic [3:0]       m1_a_size,
  input  logic [TL_RS-1:0] m1_a_source,
  input  logic [TL_AW-1:0] m1_a_address,
  input  logic [3:0]       m1_a_mask,
  input  logic [31:0]      m1_a_data,
  input  logic             m1_a_corrupt,
  input  logic             m1_a_valid,
  output logic             m1_a_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [1:0]       m1_d_param,
  output logic [3:0]       m1_d_size,
  output logic [TL_RS-1:0] m1_d_source,
  output logic             m1_d_denied,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_corrupt,
  output logic             m1_d_valid,
  input  logic             m1_d_ready,
  output logic [2:0]       s_a_opcode,
  output logic [2:0]       s_a_param,
  output logic [3:0]       s_a_size,
  output logic [TL_RS:0]   s_a_source,
  output logic [TL_AW-1:0] s_a_address,
  output logic [3:0]       s_a_mask,
  output logic [31:0]      s_a_data,
  output logic             s_a_corrupt,
  output logic             s_a_valid,
  input  logic             s_a_ready,
  input  logic [2:0]       s_d_opcode,
  input  logic [1:0]       s_d_param,
  input  logic [3:0]       s_d_size,
  input  logic [TL_RS:0]   s_d_source,
  input  logic             s_d_denied,
  input  logic [31:0]      s_d_data,
  input  logic             s_d_corrupt,
  input  logic             s_d_valid,
  output logic             s_d_ready
);
  arb_state_e r_state, w_state_nxt;
  logic       r_rr, w_rr_nxt, r_gnt, w_gnt_nxt;
  logic [9:0] r_left, w_left_nxt, w_beats_m1;
  logic       w_sel, w_sel_valid, w_hs, w_d_sel;
  // Fresh arbitration only in IDLE; HOLD/BURST stay on the registered grant.
  assign w_sel       = (r_state == ST_IDLE) ? ((m0_a_valid & m1_a_valid) ? r_rr : m1_a_valid) : r_gnt;
  assign w_sel_valid = w_sel ? m1_a_valid : m0_a_valid;
  assign s_a_valid   = ~arb_reset_i & w_sel_valid;
  assign w_hs        = s_a_valid & s_a_ready;
  assign m0_a_ready  = ~arb_reset_i & s_a_ready & ~w_sel;
  assign m1_a_ready  = ~arb_reset_i & s_a_ready & w_sel;
  assign s_a_opcode  = w_sel ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = w_sel ? m1_a_param   : m0_a_param;
  assign s_a_size    = w_sel ? m1_a_size    : m0_a_size;
  assign s_a_source  = {w_sel, w_sel ? m1_a_source : m0_a_source};
  assign s_a_address = w_sel ? m1_a_address : m0_a_address;
  assign s_a_mask    = w_sel ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = w_sel ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = w_sel ? m1_a_corrupt : m0_a_corrupt;
  assign w_beats_m1  = beats_m1(s_a_opcode, s_a_size);
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_gnt_nxt   = r_gnt;
    w_left_nxt  = r_left;
    if (r_state == ST_BURST) begin
      if (w_hs) begin
        w_left_nxt = r_left - 10'd1;
        if (r_left == 10'd1) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = ~r_gnt;
        end
      end
    end else begin
      w_gnt_nxt = w_sel;
      if (w_hs) begin
        w_state_nxt = (w_beats_m1 == 10'd0) ? ST_IDLE : ST_BURST;
        w_rr_nxt    = (w_beats_m1 == 10'd0) ? ~w_sel : r_rr;
        w_left_nxt  = w_beats_m1;
      end else begin
        // A presented-but-stalled request freezes the grant until accepted.
        w_state_nxt = w_sel_valid ? ST_HOLD : ST_IDLE;
      end
    end
  end
  always_ff @(posedge arb_clock_i) begin
    if (arb_reset_i) begin
      r_state <= ST_IDLE;
      r_rr    <= 1'b0;
      r_gnt   <= 1'b0;
      r_left  <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_left  <= w_left_nxt;
    end
  end
  // D responses are steered purely by the source MSB appended on the A side.
  assign w_d_sel      = s_d_source[TL_RS];
  assign m0_d_valid   = ~arb_reset_i & s_d_valid & ~w_d_sel;
  assign m1_d_valid   = ~arb_reset_i & s_d_valid & w_d_sel;
  assign s_d_ready    = ~arb_reset_i & (w_d_sel ? m1_d_ready : m0_d_ready);
  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[TL_RS-1:0];
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;
  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source[TL_RS-1:0];
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;
endmodule

// File: tb/tb_tlul_arbiter2.sv
// tb_tlul_arbiter2: directed scoreboard bench for tlul_arbiter2
module tb_tlul_arbiter2;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [3:0] m0_a_size, m0_a_mask, m1_a_size, m1_a_mask;
  logic [3:0] m0_a_source, m1_a_source;
  logic [15:0] m0_a_address, m1_a_address;
  logic [31:0] m0_a_data, m1_a_data;
  logic m0_a_corrupt, m0_a_valid, m0_a_ready, m1_a_corrupt, m1_a_valid, m1_a_ready;
  logic [2:0] m0_d_opcode, m1_d_opcode;
  logic [1:0] m0_d_param, m1_d_param;
  logic [3:0] m0_d_size, m1_d_size, m0_d_source, m1_d_source;
  logic m0_d_denied, m0_d_corrupt, m0_d_valid, m0_d_ready;
  logic m1_d_denied, m1_d_corrupt, m1_d_valid, m1_d_ready;
  logic [31:0] m0_d_data, m1_d_data;
  logic [2:0] s_a_opcode, s_a_param;
  logic [3:0] s_a_size, s_a_mask;
  logic [4:0] s_a_source;
  logic [15:0] s_a_address;
  logic [31:0] s_a_data;
  logic s_a_corrupt, s_a_valid, s_a_ready;
  logic [2:0] s_d_opcode;
  logic [1:0] s_d_param;
  logic [3:0] s_d_size;
  logic [4:0] s_d_source;
  logic s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
  logic [31:0] s_d_data;
  int errors = 0, checks = 0;
  logic [55:0] a_q[$];
  logic [39:0] d_q[$];

  tlul_arbiter2 #(.TL_RS(4), .TL_AW(16)) dut (
    .arb_clock_i(clk), .arb_reset_i(rst),
    .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
    .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask),
    .m0_a_data(m0_a_data), .m0_a_corrupt(m0_a_corrupt), .m0_a_valid(m0_a_valid),
    .m0_a_ready(m0_a_ready),
    .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
    .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
    .m0_d_corrupt(m0_d_corrupt), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
    .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask),
    .m1_a_data(m1_a_data), .m1_a_corrupt(m1_a_corrupt), .m1_a_valid(m1_a_valid),
    .m1_a_ready(m1_a_ready),
    .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
    .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
    .m1_d_corrupt(m1_d_corrupt), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid),
    .s_a_ready(s_a_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_source(s_d_source), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
    .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [15:0] adr, input logic [31:0] dat);
    m0_a_valid = v; m0_a_opcode = op; m0_a_size = sz; m0_a_source = src; m0_a_address = adr; m0_a_data = dat;
  endtask

  task automatic m1_req(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [15:0] adr, input logic [31:0] dat);
    m1_a_valid = v; m1_a_opcode = op; m1_a_size = sz; m1_a_source = src; m1_a_address = adr; m1_a_data = dat;
  endtask

  task automatic a_push(input logic [4:0] src, input logic [2:0] op, input logic [15:0] adr, input logic [31:0] dat);
    a_q.push_back({src, op, adr, dat});
  endtask

  always @(negedge clk) begin
    if (s_a_valid && s_a_ready) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $error("FAIL a_unexpected: observed handshake src=%0h expected none", s_a_source);
      end else
        chk("a_beat", {s_a_source, s_a_opcode, s_a_address, s_a_data}, a_q.pop_front());
    end
    chk("d_onehot", {63'd0, m0_d_valid & m1_d_valid}, 64'd0);
    if (m0_d_valid && m0_d_ready)
      if (d_q.size() == 0) begin checks++; errors++; $error("FAIL d_unexpected: observed m0 beat expected none"); end
      else chk("d_beat_m0", {1'b0, m0_d_source, m0_d_opcode, m0_d_data}, d_q.pop_front());
    if (m1_d_valid && m1_d_ready)
      if (d_q.size() == 0) begin checks++; errors++; $error("FAIL d_unexpected: observed m1 beat expected none"); end
      else chk("d_beat_m1", {1'b1, m1_d_source, m1_d_opcode, m1_d_data}, d_q.pop_front());
  end

  initial begin
    m0_a_param = 3'd0; m0_a_mask = 4'hf; m0_a_corrupt = 1'b0;
    m1_a_param = 3'd0; m1_a_mask = 4'hf; m1_a_corrupt = 1'b0;
    s_d_param = 2'd0; s_d_size = 4'd2; s_d_denied = 1'b0; s_d_corrupt = 1'b0;
    s_d_opcode = 3'd1; s_d_data = 32'h0; s_d_source = 5'h03;
    m0_d_ready = 1'b1; m1_d_ready = 1'b1; s_a_ready = 1'b1;
    // reset: outputs forced low even with requests present
    m0_req(1, 3'd4, 4'd2, 4'h1, 16'h0, 32'h0);
    m1_req(1, 3'd4, 4'd2, 4'h2, 16'h0, 32'h0);
    s_d_valid = 1'b1;
    @(negedge clk);
    chk("rst_s_a_valid", s_a_valid, 0);
    chk("rst_m0_a_ready", m0_a_ready, 0);
    chk("rst_m1_a_ready", m1_a_ready, 0);
    chk("rst_m0_d_valid", m0_d_valid, 0);
    chk("rst_s_d_ready", s_d_ready, 0);
    tick;
    rst = 1'b0; m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_d_valid = 1'b0;
    // single Get from m0, response routed back to m0
    m0_req(1, 3'd4, 4'd2, 4'h3, 16'h0100, 32'h0);
    a_push(5'h03, 3'd4, 16'h0100, 32'h0);
    @(negedge clk);
    chk("t1_src", s_a_source, 5'h03);
    chk("t1_m0_rdy", m0_a_ready, 1);
    chk("t1_m1_rdy", m1_a_ready, 0);
    tick;
    m0_a_valid = 1'b0;
    s_d_valid = 1'b1; s_d_source = 5'h03; s_d_data = 32'h1234;
    d_q.push_back({1'b0, 4'h3, 3'd1, 32'h1234});
    @(negedge clk);
    chk("t1_m0_dv", m0_d_valid, 1);
    chk("t1_m1_dv", m1_d_valid, 0);
    tick;
    s_d_valid = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    // both masters streaming Gets: strict alternation from m0
    m0_req(1, 3'd4, 4'd2, 4'h2, 16'h0200, 32'h0);
    m1_req(1, 3'd4, 4'd2, 4'h5, 16'h0300, 32'h0);
    for (int i = 0; i < 4; i++) a_push((i % 2 == 0) ? 5'h02 : 5'h15, 3'd4, (i % 2 == 0) ? 16'h0200 : 16'h0300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_m0_rdy", m0_a_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_m1_rdy", m1_a_ready, (i % 2 == 0) ? 0 : 1);
      tick;
    end
    m0_a_valid = 1'b0; m1_a_valid = 1'b0;
    // m1 4-beat PutFullData locks out m0, including a bubble mid-burst
    m1_req(1, 3'd0, 4'd4, 4'h1, 16'h0400, 32'hA0);
    a_push(5'h11, 3'd0, 16'h0400, 32'hA0);
    @(negedge clk);
    chk("t3_m1_rdy0", m1_a_ready, 1);
    tick;
    m0_req(1, 3'd4, 4'd2, 4'h4, 16'h0500, 32'h0);
    for (int i = 1; i < 4; i++) begin
      if (i == 2) begin
        m1_a_valid = 1'b0;
        @(negedge clk);
        chk("t3_gap_valid", s_a_valid, 0);
        chk("t3_gap_m0_rdy", m0_a_ready, 0);
        tick;
      end
      m1_req(1, 3'd0, 4'd4, 4'h1, 16'h0400, 32'hA0 + i);
      a_push(5'h11, 3'd0, 16'h0400, 32'hA0 + i);
      @(negedge clk);
      chk("t3_m0_rdy", m0_a_ready, 0);
      chk("t3_m1_rdy", m1_a_ready, 1);
      tick;
    end
    m1_a_valid = 1'b0;
    a_push(5'h04, 3'd4, 16'h0500, 32'h0);
    @(negedge clk);
    chk("t3_m0_after", m0_a_ready, 1);
    tick;
    m0_a_valid = 1'b0;
    // stalled m0 request holds the grant although rr now prefers m1
    s_a_ready = 1'b0;
    m0_req(1, 3'd4, 4'd2, 4'h6, 16'h0600, 32'h0);
    @(negedge clk);
    chk("t4_src0", s_a_source, 5'h06);
    tick;
    m1_req(1, 3'd4, 4'd2, 4'h8, 16'h0700, 32'h0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_src", s_a_source, 5'h06);
      chk("t4_hold_valid", s_a_valid, 1);
      chk("t4_m1_rdy", m1_a_ready, 0);
      tick;
    end
    s_a_ready = 1'b1;
    a_push(5'h06, 3'd4, 16'h0600, 32'h0);
    @(negedge clk);
    chk("t4_m0_acc", m0_a_ready, 1);
    chk("t4_m1_wait", m1_a_ready, 0);
    tick;
    m0_a_valid = 1'b0;
    a_push(5'h18, 3'd4, 16'h0700, 32'h0);
    @(negedge clk);
    chk("t4_m1_next", m1_a_ready, 1);
    tick;
    m1_a_valid = 1'b0;
    // 8-beat read response to m1 under backpressure
    for (int b = 0; b < 8; b++) d_q.push_back({1'b1, 4'h6, 3'd1, 32'hD0 + b});
    s_d_valid = 1'b1; s_d_source = 5'h16; s_d_size = 4'd5;
    begin
      int beat = 0;
      for (int c = 0; c < 32 && beat < 8; c++) begin
        m1_d_ready = (c % 2 == 1);
        s_d_data = 32'hD0 + beat;
        @(negedge clk);
        chk("t5_s_d_ready", s_d_ready, m1_d_ready);
        chk("t5_m1_dv", m1_d_valid, 1);
        chk("t5_m0_dv", m0_d_valid, 0);
        tick;
        if (m1_d_ready) beat++;
      end
    end
    s_d_valid = 1'b0; m1_d_ready = 1'b1; s_d_size = 4'd2;
    // reset during beat 2 of a 16-beat burst aborts the lock
    for (int i = 0; i < 2; i++) begin
      m0_req(1, 3'd0, 4'd6, 4'h9, 16'h0800, 32'hB0 + i);
      a_push(5'h09, 3'd0, 16'h0800, 32'hB0 + i);
      @(negedge clk);
      tick;
    end
    m0_req(1, 3'd0, 4'd6, 4'h9, 16'h0800, 32'hB2);
    m1_req(1, 3'd4, 4'd2, 4'h7, 16'h0900, 32'h0);
    s_d_valid = 1'b1; s_d_source = 5'h03;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", s_a_valid, 0);
    chk("t6_rst_m0_rdy", m0_a_ready, 0);
    chk("t6_rst_m1_rdy", m1_a_ready, 0);
    chk("t6_rst_m0_dv", m0_d_valid, 0);
    chk("t6_rst_s_d_rdy", s_d_ready, 0);
    tick;
    rst = 1'b0; m0_a_valid = 1'b0; s_d_valid = 1'b0;
    a_push(5'h17, 3'd4, 16'h0900, 32'h0);
    @(negedge clk);
    chk("t6_m1_rdy", m1_a_ready, 1);
    chk("t6_m1_src", s_a_source, 5'h17);
    tick;
    m1_a_valid = 1'b0;
    tick;
    chk("a_sb_empty", a_q.size(), 0);
    chk("d_sb_empty", d_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
